// File: rtl/hcf_pkg.sv
// Shared definitions for the iterative HCF (GCD) execution unit.
// The state encoding, ALU opcode and default width live here so every file agrees on them.
package hcf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } hcf_state_e;

  localparam logic [3:0] ALU_OP_HCF = 4'b1001;
  localparam int         HCF_WIDTH  = 32;

endpackage

// File: rtl/hcf_step.sv
// One binary-GCD (Stein) iteration: purely combinational next-state for a, b and k.
// The caller registers the outputs; finish/final_value report termination.
module hcf_step
  import hcf_pkg::*;
#(
  parameter int WIDTH = HCF_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] next_a,
  output logic [WIDTH-1:0] next_b,
  output logic [KW-1:0]    next_k,
  output logic             finish,
  output logic [WIDTH-1:0] final_value
);

  logic             w_a_even;
  logic             w_b_even;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;

  assign w_a_even    = ~a[0];
  assign w_b_even    = ~b[0];
  assign w_a_minus_b = a - b;
  assign w_b_minus_a = b - a;

  // Branch order matters: the odd/odd subtraction is only reached with a, b nonzero,
  // and the comparison picks the operand that cannot underflow.
  always_comb begin
    next_a      = a;
    next_b      = b;
    next_k      = k;
    finish      = 1'b0;
    final_value = '0;
    if (a == '0) begin
      finish      = 1'b1;
      final_value = b << k;
    end else if (b == '0) begin
      finish      = 1'b1;
      final_value = a << k;
    end else if (w_a_even && w_b_even) begin
      next_a = a >> 1;
      next_b = b >> 1;
      next_k = k + KW'(1);
    end else if (w_a_even) begin
      next_a = a >> 1;
    end else if (w_b_even) begin
      next_b = b >> 1;
    end else if (a >= b) begin
      next_a = w_a_minus_b >> 1;
    end else begin
      next_b = w_b_minus_a >> 1;
    end
  end

endmodule

// File: rtl/hcf_iterative_unit.sv
// Multi-cycle HCF unit: accepts an operand pair, runs one Stein step per clock,
// and holds the result on a valid/ready response channel until it is taken.
module hcf_iterative_unit
  import hcf_pkg::*;
#(
  parameter int WIDTH = HCF_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero_flag,
  output logic             busy
);

  hcf_state_e       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_busy;

  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;
  logic [KW-1:0]    w_next_k;
  logic             w_finish;
  logic [WIDTH-1:0] w_final;

  hcf_step #(
    .WIDTH(WIDTH),
    .KW   (KW)
  ) u_step (
    .a          (r_a),
    .b          (r_b),
    .k          (r_k),
    .next_a     (w_next_a),
    .next_b     (w_next_b),
    .next_k     (w_next_k),
    .finish     (w_finish),
    .final_value(w_final)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_k         <= '0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in1;
            r_b     <= in2;
            r_k     <= '0;
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (w_finish) begin
            r_result    <= w_final;
            r_zero      <= (w_final == '0);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_a <= w_next_a;
            r_b <= w_next_b;
            r_k <= w_next_k;
          end
        end
        DONE: begin
          // No accept here: the next request waits for the IDLE cycle that follows.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = r_out_valid;
  assign busy       = r_busy;
  assign alu_result = r_result;
  assign zero_flag  = r_zero;

endmodule
